// File: rtl/seg_count_display.sv
// -----------------------------------------------------------------------------
// seg_count_display
//
// Purpose:
//   Consumes one-cycle clean inc/dec/clr pulses from the debouncers and keeps
//   a 4-digit BCD counter (0000-9999, wrapping both ways). The counter value
//   is time-multiplexed onto a common-anode 4-digit seven-segment display.
//
// Parameters:
//   SCAN_DIV  clk cycles each digit stays active (>= 2)
//   SCAN_W    width of the scan prescaler; 2**SCAN_W must be >= SCAN_DIV
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high; overrides every other input
//   inc        in   one-cycle pulse, count + 1
//   dec        in   one-cycle pulse, count - 1
//   clr        in   one-cycle pulse, count := 0000 (highest priority)
//   count_bcd  out  registered count {d3,d2,d1,d0}, d0 = ones
//   an         out  active-low digit enables, exactly one bit low, an[0] = ones
//   seg        out  active-low segments {g,f,e,d,c,b,a}
//   dp         out  active-low decimal point, always off
//
// Build option:
//   SEG_LEADING_ZERO_BLANK_EN  when defined, digits above the most-significant
//                              nonzero digit are blanked (digit 0 never is).
//                              Scan timing and count_bcd are unaffected.
// -----------------------------------------------------------------------------
module seg_count_display #(
    parameter int SCAN_DIV = 50000,
    parameter int SCAN_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        dec,
    input  logic        clr,
    output logic [15:0] count_bcd,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // BCD increment with ripple carry; 9999 wraps to 0000. Any digit that is
    // somehow above 9 is folded back to 0 so no digit can stay illegal.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD decrement with ripple borrow; 0000 wraps to 9999.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                    borrow      = 1'b1;
                end else if (v[4*i +: 4] > 4'd9) begin
                    r[4*i +: 4] = 4'd9;
                    borrow      = 1'b0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Active-low glyphs {g..a}; non-BCD nibbles show a dash.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    logic [15:0]       count_q, count_d;
    logic [SCAN_W-1:0] scan_q,  scan_d;
    logic [1:0]        digit_q, digit_d;
    logic [3:0]        an_q,    an_d;
    logic [6:0]        seg_q,   seg_d;
    logic              scan_wrap;
    logic [3:0]        cur_nibble;
    logic              blank;

    // Counter: clr wins; inc and dec together cancel.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 16'h0000;
        end else if (inc && !dec) begin
            count_d = bcd_inc(count_q);
        end else if (dec && !inc) begin
            count_d = bcd_dec(count_q);
        end
    end

    // Scan engine: prescaler wrap advances the digit index 0..3.
    always_comb begin
        scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));
        scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
        digit_d   = scan_wrap ? digit_q + 2'd1 : digit_q;
    end

    // Output stage: decode the current digit index and count nibble.
    always_comb begin
        cur_nibble = count_q[{digit_q, 2'b00} +: 4];
        blank      = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every digit above it is zero.
        case (digit_q)
            2'd1:    blank = (count_q[15:4]  == 12'h000);
            2'd2:    blank = (count_q[15:8]  == 8'h00);
            2'd3:    blank = (count_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
`endif
        an_d  = ~(4'b0001 << digit_q);
        seg_d = blank ? SEG_BLANK : glyph(cur_nibble);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 16'h0000;
            scan_q  <= '0;
            digit_q <= 2'd0;
            an_q    <= 4'b1110;
            seg_q   <= SEG_ZERO;
        end else begin
            count_q <= count_d;
            scan_q  <= scan_d;
            digit_q <= digit_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign count_bcd = count_q;
    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = 1'b1;

endmodule

// File: tb/tb_seg_count_display.sv
// -----------------------------------------------------------------------------
// tb_seg_count_display
//
// Self-checking bench for seg_count_display with SCAN_DIV = 4. An integer
// model of the count (0..9999) and a cycle count since reset release give the
// expected counter, anode and segment values.
// -----------------------------------------------------------------------------
module tb_seg_count_display;

    localparam int SD = 4;
    localparam logic [6:0] GLYPH [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inc = 1'b0;
    logic        dec = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] count_bcd;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    // Model state: current count, count before the last edge, edges since reset.
    int mc = 0;
    int mp = 0;
    int m  = 0;

    seg_count_display #(.SCAN_DIV(SD), .SCAN_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .inc       (inc),
        .dec       (dec),
        .clr       (clr),
        .count_bcd (count_bcd),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Digit shown on the pins after mm edges: pins lag the scan by one cycle.
    function automatic int pin_digit(input int mm);
        return (mm == 0) ? 0 : ((mm - 1) / SD) % 4;
    endfunction

    function automatic logic [3:0] exp_an(input int mm);
        logic [3:0] a;
        a = 4'b1111;
        a[pin_digit(mm)] = 1'b0;
        return a;
    endfunction

    function automatic logic [6:0] exp_seg(input int mm, input int v);
        int d;
        int p;
        d = pin_digit(mm);
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (d > 0 && v < p) return 7'b1111111;
`endif
        return GLYPH[(v / p) % 10];
    endfunction

    task automatic tick(input logic r, input logic i, input logic d, input logic c);
        reset = r; inc = i; dec = d; clr = c;
        @(posedge clk);
        #1;
        mp = mc;
        if (r) begin
            mc = 0; mp = 0; m = 0;
        end else begin
            m++;
            if (c)               mc = 0;
            else if (i && !d)    mc = (mc + 1) % 10000;
            else if (d && !i)    mc = (mc + 9999) % 10000;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
        checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL reset_count got %h want 0000", count_bcd); end
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset_an got %b want 1110", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg got %b want 1000000", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", dp); end
    endtask

    task automatic test_scan();
        for (int i = 0; i < 4 * SD + 4; i++) begin
            tick(0, 0, 0, 0);
            checks++; if (an !== exp_an(m)) begin errors++; $display("FAIL scan_an m=%0d got %b want %b", m, an, exp_an(m)); end
            checks++; if (seg !== exp_seg(m, mp)) begin errors++; $display("FAIL scan_seg m=%0d got %b want %b", m, seg, exp_seg(m, mp)); end
        end
    endtask

    task automatic test_inc12();
        for (int i = 0; i < 12; i++) begin
            tick(0, 1, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        end
        checks++; if (count_bcd !== 16'h0012) begin errors++; $display("FAIL inc12_count got %h want 0012", count_bcd); end
        for (int i = 0; i < 4 * SD; i++) begin
            tick(0, 0, 0, 0);
            if (an == 4'b1110) begin
                checks++; if (seg !== 7'b0100100) begin errors++; $display("FAIL inc12_ones got %b want 0100100", seg); end
            end
            if (an == 4'b1101) begin
                checks++; if (seg !== 7'b1111001) begin errors++; $display("FAIL inc12_tens got %b want 1111001", seg); end
            end
            checks++; if (an !== exp_an(m)) begin errors++; $display("FAIL inc12_an got %b want %b", an, exp_an(m)); end
        end
    endtask

    task automatic test_wrap();
        tick(0, 0, 0, 1);
        tick(0, 0, 1, 0);
        checks++; if (count_bcd !== 16'h9999) begin errors++; $display("FAIL wrap_down1 got %h want 9999", count_bcd); end
        tick(0, 1, 0, 0);
        checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL wrap_up got %h want 0000", count_bcd); end
        tick(0, 0, 1, 0);
        checks++; if (count_bcd !== 16'h9999) begin errors++; $display("FAIL wrap_down2 got %h want 9999", count_bcd); end
        tick(0, 0, 0, 0);
        for (int i = 0; i < 4 * SD; i++) begin
            tick(0, 0, 0, 0);
            checks++; if (seg !== 7'b0010000) begin errors++; $display("FAIL wrap_nines an=%b got %b want 0010000", an, seg); end
        end
    endtask

    task automatic test_same_cycle();
        tick(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
        tick(0, 1, 1, 0);
        checks++; if (count_bcd !== 16'h0005) begin errors++; $display("FAIL incdec got %h want 0005", count_bcd); end
        tick(0, 1, 0, 1);
        checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL clrinc got %h want 0000", count_bcd); end
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
        tick(0, 0, 1, 1);
        checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL clrdec got %h want 0000", count_bcd); end
        checks++; if (count_bcd !== to_bcd(mc)) begin errors++; $display("FAIL same_model got %h want %h", count_bcd, to_bcd(mc)); end
    endtask

    task automatic test_carry_borrow();
        tick(0, 0, 0, 1);
        for (int i = 0; i < 99; i++) tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        checks++; if (count_bcd !== 16'h0100) begin errors++; $display("FAIL carry99 got %h want 0100", count_bcd); end
        tick(0, 0, 0, 1);
        for (int i = 0; i < 1000; i++) tick(0, 1, 0, 0);
        tick(0, 0, 1, 0);
        checks++; if (count_bcd !== 16'h0999) begin errors++; $display("FAIL borrow1000 got %h want 0999", count_bcd); end
        tick(0, 0, 0, 1);
        for (int i = 0; i < 909; i++) tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        checks++; if (count_bcd !== 16'h0910) begin errors++; $display("FAIL carry909 got %h want 0910", count_bcd); end
    endtask

    task automatic test_blank();
        logic [6:0] lead;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        lead = 7'b1111111;
`else
        lead = 7'b1000000;
`endif
        tick(0, 0, 0, 1);
        for (int i = 0; i < 42; i++) tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 4 * SD; i++) begin
            tick(0, 0, 0, 0);
            case (an)
                4'b1110: begin checks++; if (seg !== 7'b0100100) begin errors++; $display("FAIL b42_d0 got %b want 0100100", seg); end end
                4'b1101: begin checks++; if (seg !== 7'b0011001) begin errors++; $display("FAIL b42_d1 got %b want 0011001", seg); end end
                default: begin checks++; if (seg !== lead) begin errors++; $display("FAIL b42_lead an=%b got %b want %b", an, seg, lead); end end
            endcase
        end
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 4 * SD; i++) begin
            tick(0, 0, 0, 0);
            if (an == 4'b1110) begin
                checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL b0_d0 got %b want 1000000", seg); end
            end else begin
                checks++; if (seg !== lead) begin errors++; $display("FAIL b0_lead an=%b got %b want %b", an, seg, lead); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick(0, 1'($urandom % 2), 1'($urandom % 2), 1'(($urandom % 10) == 0));
            checks++; if (count_bcd !== to_bcd(mc)) begin errors++; $display("FAIL rnd_count i=%0d got %h want %h", i, count_bcd, to_bcd(mc)); end
            checks++; if (an !== exp_an(m)) begin errors++; $display("FAIL rnd_an i=%0d got %b want %b", i, an, exp_an(m)); end
            checks++; if (seg !== exp_seg(m, mp)) begin errors++; $display("FAIL rnd_seg i=%0d got %b want %b", i, seg, exp_seg(m, mp)); end
            checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rnd_dp i=%0d got %b want 1", i, dp); end
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 37; i++) tick(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);
        tick(1, 1, 0, 0);
        checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL mid_count got %h want 0000", count_bcd); end
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL mid_an got %b want 1110", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL mid_seg got %b want 1000000", seg); end
        for (int i = 0; i < 4 * SD + 2; i++) begin
            tick(0, 0, 0, 0);
            checks++; if (an !== exp_an(m)) begin errors++; $display("FAIL mid_scan m=%0d got %b want %b", m, an, exp_an(m)); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_inc12();
        test_wrap();
        test_same_cycle();
        test_carry_borrow();
        test_blank();
        test_random();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_count_display.md
Name: seg_count_display

Overview:
Consumer end of the debounced-button interface. Takes one-cycle clean increment, decrement and clear pulses, as produced by the team's debouncer blocks, and maintains a 4-digit BCD counter (0000-9999). The block time-multiplexes the counter value onto a common-anode 4-digit seven-segment display. It sits between the debouncers and the board display pins.

Parameters:
SCAN_DIV, 50000, clk cycles each digit is held active before advancing to the next digit; legal range >= 2.
SCAN_W, 16, width of the scan prescaler counter; must satisfy 2**SCAN_W >= SCAN_DIV.

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high
inc  input  1  one-cycle clean pulse: count +1
dec  input  1  one-cycle clean pulse: count -1
clr  input  1  one-cycle clean pulse: count := 0000
count_bcd  output  16  registered count, {d3,d2,d1,d0}, 4 bits per digit, d0 = ones
an  output  4  active-low digit enables, one-hot-low; an[0] = ones digit
seg  output  7  active-low segments {g,f,e,d,c,b,a}
dp  output  1  active-low decimal point; tied 1 (off)

Behaviour:
- All state is synchronous to clk. reset is sampled on clk and overrides every other input.
- Reset values:
  - count_bcd = 16'h0000
  - scan prescaler = 0
  - digit index = 0
  - an = 4'b1110
  - seg = 7'b1000000 (the "0" glyph)
  - dp = 1
- Counter update, one cycle after the input pulse is sampled. Priority is clr > (inc XOR dec):
  - clr = 1: count := 0000. inc and dec are ignored that cycle.
  - inc = 1, dec = 0: BCD increment. A digit at 9 becomes 0 and carries into the next digit. 9999 -> 0000 (wrap).
  - dec = 1, inc = 0: BCD decrement. A digit at 0 becomes 9 and borrows from the next digit. 0000 -> 9999 (wrap).
  - inc = 1 and dec = 1: no change.
  - An input held high for N cycles is treated as N pulses. Sources are required to drive single-cycle pulses.
  - No digit of count_bcd ever holds a value above 9.
- Scan engine:
  - The prescaler counts 0..SCAN_DIV-1, then wraps to 0.
  - On the wrap, the digit index advances 0 -> 1 -> 2 -> 3 -> 0.
  - Each digit is therefore active for exactly SCAN_DIV cycles. A full frame is 4*SCAN_DIV cycles.
  - The scan runs continuously and is unaffected by inc, dec and clr.
- Output stage:
  - an and seg are registered from the current digit index and the current count_bcd.
  - Latency is 1 cycle from a digit-index change or count change to the pins.
  - an is always exactly one bit low. No all-off or multi-on state ever appears, including across reset.
- Glyph map for seg, active-low {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any other nibble displays 0111111 (dash). This case is unreachable in normal operation.
- Reset asserted mid-frame: the next cycle returns to the reset values. Scanning restarts at digit 0 with a fresh SCAN_DIV period.

Optional Feature:
SEG_LEADING_ZERO_BLANK_EN.
- Defined: any digit above the most-significant nonzero digit displays seg = 7'b1111111 (blank). Its anode is still driven low in its scan slot, so scan timing is unchanged. Digit 0 is never blanked, so 0000 shows as "0". Examples: 0042 shows as "  42"; 1003 shows all four digits.
- Not defined: all four digits are always shown, including leading zeros.
- count_bcd is identical in both builds.

Test Plan:
- Reset, SCAN_DIV=4: hold reset 3 cycles, release -> count_bcd=0000, an=1110, seg=1000000. an steps 1110 -> 1101 -> 1011 -> 0111 -> 1110, each held 4 cycles.
- 12 inc pulses spaced 3 cycles apart -> count_bcd=0012. During the ones slot seg=0100100; during the tens slot seg=1111001.
- Preload to 9999 via 1 dec from 0000 (giving 9999), then 1 inc -> 0000. Then 1 dec -> 9999; every digit slot shows 0010000.
- Same-cycle events from 0005: inc & dec together -> stays 0005. clr & inc together -> 0000. clr & dec together -> 0000.
- Carry and borrow chains: 0099 + inc -> 0100; 1000 + dec -> 0999; 0909 + inc -> 0910.
- With SEG_LEADING_ZERO_BLANK_EN defined, count 0042 -> digit 3 and 2 slots seg=1111111, digit 1 slot 0011001, digit 0 slot 0100100. At count 0000 -> digit 0 slot 1000000, other slots blank. Without the macro, digit 3 and 2 slots show 1000000.
